// File: rtl/bcd_magic_square_checker.sv
// Registered Lo Shu magic-square checker for a 3x3 grid of BCD digits.
// Results (uniqueness, magic flag, packed-BCD top-row sum, BCD error) appear one cycle after in_valid.
module bcd_magic_square_checker (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [3:0] num1,
  input  logic [3:0] num2,
  input  logic [3:0] num3,
  input  logic [3:0] num4,
  input  logic [3:0] num5,
  input  logic [3:0] num6,
  input  logic [3:0] num7,
  input  logic [3:0] num8,
  input  logic [3:0] num9,
  output logic       out_valid,
  output logic       unique_valid,
  output logic       it_is_magic,
  output logic [7:0] magic_constant,
  output logic       bcd_error
);

  // One-digit BCD add: returns {cout, sum digit}.
  function automatic logic [4:0] bcd_add1(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [4:0] t;
    t = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    if (t > 5'd9) begin
      t = t + 5'd6;
      bcd_add1 = {1'b1, t[3:0]};
    end else begin
      bcd_add1 = {1'b0, t[3:0]};
    end
  endfunction

  function automatic logic [7:0] bcd_sum3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    logic [4:0] r1;
    logic [4:0] r2;
    r1 = bcd_add1(a, b, 1'b0);
    r2 = bcd_add1(r1[3:0], c, 1'b0);
    bcd_sum3 = {{3'd0, r1[4]} + {3'd0, r2[4]}, r2[3:0]};
  endfunction

  logic [3:0] dig_s [9];
  logic [7:0] sum_s [8];
  logic [8:0] presence_s;
  logic       err_s;
  logic       zero_s;
  logic       uniq_s;
  logic       all_eq_s;

  logic       out_valid_q, out_valid_d;
  logic       unique_q, unique_d;
  logic       magic_q, magic_d;
  logic [7:0] const_q, const_d;
  logic       err_q, err_d;

  assign dig_s[0] = num1;
  assign dig_s[1] = num2;
  assign dig_s[2] = num3;
  assign dig_s[3] = num4;
  assign dig_s[4] = num5;
  assign dig_s[5] = num6;
  assign dig_s[6] = num7;
  assign dig_s[7] = num8;
  assign dig_s[8] = num9;

  assign sum_s[0] = bcd_sum3(num1, num2, num3);
  assign sum_s[1] = bcd_sum3(num4, num5, num6);
  assign sum_s[2] = bcd_sum3(num7, num8, num9);
  assign sum_s[3] = bcd_sum3(num1, num4, num7);
  assign sum_s[4] = bcd_sum3(num2, num5, num8);
  assign sum_s[5] = bcd_sum3(num3, num6, num9);
  assign sum_s[6] = bcd_sum3(num1, num5, num9);
  assign sum_s[7] = bcd_sum3(num3, num5, num7);

  // Presence vector: with nine digits, all nine bits set means each of 1..9 occurs exactly once.
  always_comb begin
    presence_s = 9'd0;
    err_s      = 1'b0;
    zero_s     = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (dig_s[i] > 4'd9) begin
        err_s = 1'b1;
      end else if (dig_s[i] != 4'd0) begin
        presence_s[dig_s[i] - 4'd1] = 1'b1;
      end else begin
        zero_s = 1'b1;
      end
    end
    uniq_s   = (&presence_s) & ~err_s & ~zero_s;
    all_eq_s = 1'b1;
    for (int j = 1; j < 8; j++) begin
      if (sum_s[j] != sum_s[0]) begin
        all_eq_s = 1'b0;
      end else begin
        all_eq_s = all_eq_s;
      end
    end
  end

  // Next-state: results load on in_valid and hold otherwise.
  always_comb begin
    out_valid_d = in_valid;
    unique_d    = unique_q;
    magic_d     = magic_q;
    const_d     = const_q;
    err_d       = err_q;
    if (in_valid) begin
      if (err_s) begin
        unique_d = 1'b0;
        magic_d  = 1'b0;
        const_d  = 8'h00;
        err_d    = 1'b1;
      end else begin
        unique_d = uniq_s;
        magic_d  = uniq_s & all_eq_s;
        const_d  = sum_s[0];
        err_d    = 1'b0;
      end
    end else begin
      err_d = err_q;
    end
  end

  // Result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      unique_q    <= 1'b0;
      magic_q     <= 1'b0;
      const_q     <= 8'h00;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      unique_q    <= unique_d;
      magic_q     <= magic_d;
      const_q     <= const_d;
      err_q       <= err_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign unique_valid   = unique_q;
  assign it_is_magic    = magic_q;
  assign magic_constant = const_q;
  assign bcd_error      = err_q;

endmodule

// File: tb/tb_bcd_magic_square_checker.sv
// Self-checking bench: directed grids from the test plan plus random grids, checked against
// an arithmetic reference model (integer line sums, digit counts, decimal-to-BCD conversion).
module tb_bcd_magic_square_checker;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [3:0] num1, num2, num3, num4, num5, num6, num7, num8, num9;
  logic       out_valid, unique_valid, it_is_magic, bcd_error;
  logic [7:0] magic_constant;

  int n_assert = 0;
  int n_fail   = 0;

  logic       exp_ov = 1'b0, exp_uq = 1'b0, exp_mg = 1'b0, exp_er = 1'b0;
  logic [7:0] exp_mc = 8'h00;

  bcd_magic_square_checker dut (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .num1(num1), .num2(num2), .num3(num3), .num4(num4), .num5(num5),
    .num6(num6), .num7(num7), .num8(num8), .num9(num9),
    .out_valid(out_valid), .unique_valid(unique_valid), .it_is_magic(it_is_magic),
    .magic_constant(magic_constant), .bcd_error(bcd_error)
  );

  always #5 clock = ~clock;

  typedef int grid_t [9];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out_valid"},      {7'd0, out_valid},    {7'd0, exp_ov});
    check({tag, ".unique_valid"},   {7'd0, unique_valid}, {7'd0, exp_uq});
    check({tag, ".it_is_magic"},    {7'd0, it_is_magic},  {7'd0, exp_mg});
    check({tag, ".magic_constant"}, magic_constant,       exp_mc);
    check({tag, ".bcd_error"},      {7'd0, bcd_error},    {7'd0, exp_er});
  endtask

  // Reference model: plain decimal arithmetic over the grid.
  task automatic model(input grid_t g);
    int cnt [16];
    int s [8];
    bit err, uq, eq;
    for (int i = 0; i < 16; i++) cnt[i] = 0;
    err = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cnt[g[i]]++;
      if (g[i] > 9) err = 1'b1;
    end
    uq = 1'b1;
    for (int v = 1; v <= 9; v++) if (cnt[v] != 1) uq = 1'b0;
    s[0] = g[0] + g[1] + g[2];
    s[1] = g[3] + g[4] + g[5];
    s[2] = g[6] + g[7] + g[8];
    s[3] = g[0] + g[3] + g[6];
    s[4] = g[1] + g[4] + g[7];
    s[5] = g[2] + g[5] + g[8];
    s[6] = g[0] + g[4] + g[8];
    s[7] = g[2] + g[4] + g[6];
    eq = 1'b1;
    for (int k = 1; k < 8; k++) if (s[k] != s[0]) eq = 1'b0;
    exp_er = err;
    exp_uq = err ? 1'b0 : uq;
    exp_mg = err ? 1'b0 : (uq && eq);
    exp_mc = err ? 8'h00 : 8'((s[0] / 10) * 16 + (s[0] % 10));
  endtask

  task automatic drive(input grid_t g, input logic v);
    num1 = 4'(g[0]); num2 = 4'(g[1]); num3 = 4'(g[2]);
    num4 = 4'(g[3]); num5 = 4'(g[4]); num6 = 4'(g[5]);
    num7 = 4'(g[6]); num8 = 4'(g[7]); num9 = 4'(g[8]);
    in_valid = v;
  endtask

  // Apply one grid for one cycle, then compare after the edge.
  task automatic step(input string tag, input grid_t g, input logic v);
    @(negedge clock);
    drive(g, v);
    @(posedge clock);
    if (v) model(g);
    exp_ov = v;
    #1;
    check_all(tag);
  endtask

  function automatic grid_t rot(input grid_t g);
    grid_t r;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        r[rr*3+cc] = g[(2-cc)*3+rr];
    return r;
  endfunction

  function automatic grid_t mirror(input grid_t g);
    grid_t r;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        r[rr*3+cc] = g[rr*3+2-cc];
    return r;
  endfunction

  initial begin
    grid_t g;
    grid_t lo_shu;
    int tmp, j, mode;

    reset = 1'b1;
    g = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    drive(g, 1'b0);
    #1;
    check_all("por");
    #20;
    @(negedge clock);
    reset = 1'b0;

    step("zeros", '{0, 0, 0, 0, 0, 0, 0, 0, 0}, 1'b1);
    lo_shu = '{2, 7, 6, 9, 5, 1, 4, 3, 8};
    step("magicA", lo_shu, 1'b1);
    step("magicB", '{6, 1, 8, 7, 5, 3, 2, 9, 4}, 1'b1);
    step("dupA",   '{9, 2, 4, 6, 1, 7, 3, 7, 9}, 1'b1);
    step("dupB",   '{1, 1, 2, 5, 2, 7, 8, 2, 9}, 1'b1);
    step("c570",   '{5, 7, 0, 1, 1, 1, 1, 1, 1}, 1'b1);
    step("c890",   '{8, 9, 0, 1, 1, 1, 1, 1, 1}, 1'b1);
    step("c130",   '{1, 3, 0, 1, 1, 1, 1, 1, 1}, 1'b1);
    step("c123",   '{1, 2, 3, 0, 0, 0, 0, 0, 0}, 1'b1);
    step("c987",   '{9, 8, 7, 0, 0, 0, 0, 0, 0}, 1'b1);
    step("c239",   '{2, 3, 9, 0, 0, 0, 0, 0, 0}, 1'b1);
    step("c999",   '{9, 9, 9, 9, 9, 9, 9, 9, 9}, 1'b1);
    step("perm",   '{1, 2, 3, 4, 5, 6, 7, 8, 9}, 1'b1);
    step("bcderr", '{2, 7, 6, 9, 10, 1, 4, 3, 8}, 1'b1);
    step("magicC", lo_shu, 1'b1);
    step("hold1",  '{15, 15, 15, 0, 0, 0, 1, 2, 3}, 1'b0);
    step("hold2",  '{1, 2, 3, 4, 5, 6, 7, 8, 9}, 1'b0);

    // Random mix: symmetric Lo Shu variants, random permutations, random digits incl. non-BCD.
    for (int n = 0; n < 300; n++) begin
      mode = $urandom_range(0, 3);
      if (mode == 0) begin
        g = lo_shu;
        for (int r = 0; r < $urandom_range(0, 3); r++) g = rot(g);
        if ($urandom_range(0, 1) == 1) g = mirror(g);
      end else if (mode == 1) begin
        for (int i = 0; i < 9; i++) g[i] = i + 1;
        for (int i = 8; i > 0; i--) begin
          j = $urandom_range(0, i);
          tmp = g[i]; g[i] = g[j]; g[j] = tmp;
        end
      end else if (mode == 2) begin
        for (int i = 0; i < 9; i++) g[i] = $urandom_range(0, 9);
      end else begin
        for (int i = 0; i < 9; i++) g[i] = $urandom_range(0, 15);
      end
      step("rand", g, 1'($urandom_range(0, 4) != 0));
    end

    // Reset mid-stream: outputs clear without a clock edge.
    step("premag", lo_shu, 1'b1);
    @(negedge clock);
    drive(lo_shu, 1'b1);
    #2;
    reset = 1'b1;
    exp_ov = 1'b0; exp_uq = 1'b0; exp_mg = 1'b0; exp_mc = 8'h00; exp_er = 1'b0;
    #1;
    check_all("rstasync");
    @(posedge clock);
    #1;
    check_all("rstvalid");
    @(negedge clock);
    reset = 1'b0;
    drive(lo_shu, 1'b0);
    @(posedge clock);
    #1;
    check_all("rstdiscard");
    step("postrst", lo_shu, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
